// File: rtl/newton_raphson_divide_16_pkg.sv
// Shared constants and types for the Newton-Raphson 16-bit signed divider.
// The reciprocal estimate is Q2.16 held in 18 bits.
package newton_raphson_pkg;
    localparam int WIDTH    = 16;
    localparam int FRAC     = 16;
    localparam int NR_ITERS = 3;
    localparam int LATENCY  = 6;

    typedef logic [17:0] recip_t;

    localparam recip_t C48_17 = 18'd185043;
    localparam recip_t C32_17 = 18'd123362;
    localparam recip_t TWO_Q  = 18'd131072;

    // Operand bookkeeping that travels alongside the reciprocal
    typedef struct packed {
        logic [WIDTH-1:0] abs_n;
        logic [WIDTH-1:0] abs_d;
        logic [WIDTH-1:0] dn;
        logic [4:0]       lz;
        logic             neg;
        logic             div0;
        logic             ovf;
        logic             nzero;
    } op_t;
endpackage

// File: rtl/newton_raphson_divide_16_if.sv
// Operand/result bundle for the divider; master drives operands, slave returns Q.
interface newton_raphson_divide_16_if;
    logic        in_valid;
    logic [15:0] N;
    logic [15:0] D;
    logic        out_valid;
    logic [15:0] Q;

    modport master (output in_valid, N, D, input  out_valid, Q);
    modport slave  (input  in_valid, N, D, output out_valid, Q);
endinterface

// File: rtl/newton_raphson_divide_16_lzc16.sv
// Combinational 16-bit leading-zero counter; zero input yields 16.
module lzc16 (
    input  logic [15:0] a,
    output logic [4:0]  cnt
);
    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        cnt = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (a[i]) cnt = 5'(15 - i);
        end
    end
endmodule

// File: rtl/newton_raphson_divide_16.sv
// Pipelined signed 16-bit divider: normalise divisor, refine reciprocal with
// three Newton-Raphson steps, multiply, then a single +/-1 correction.
module newton_raphson_divide_16
    import newton_raphson_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    newton_raphson_divide_16_if.slave bus
);
    logic [LATENCY:0] vld_pipe_q, vld_pipe_d;
    logic [WIDTH-1:0] n_q, n_d, d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    op_t              op_q [LATENCY-1:1];
    op_t              op_d [LATENCY-1:1];
    recip_t           x_q  [NR_ITERS:0];
    recip_t           x_d  [NR_ITERS:0];
    recip_t           x_nxt [NR_ITERS];

    logic [WIDTH-1:0] abs_d;
    logic [4:0]       lz;
    logic [5:0]       sh;
    logic [16:0]      q_raw, q_fix;
    logic [17:0]      rem;
    logic [WIDTH-1:0] mag;

    lzc16 u_lzc (.a(abs_d), .cnt(lz));

    // Identical iteration body X <- X*(2 - d*X), truncated to Q2.16
    for (genvar g = 0; g < NR_ITERS; g++) begin : g_nr
        recip_t e, t;
        always_comb begin
            e = 18'((34'(op_q[g+2].dn) * 34'(x_q[g])) >> FRAC);
            t = TWO_Q - e;
        end
        assign x_nxt[g] = 18'((34'(x_q[g]) * 34'(t)) >> FRAC);
    end

    assign abs_d = d_q[15] ? (~d_q + 16'd1) : d_q;

    always_comb begin
        vld_pipe_d = {vld_pipe_q[LATENCY-1:0], bus.in_valid};
        n_d        = bus.N;
        d_d        = bus.D;

        op_d[1].abs_n = n_q[15] ? (~n_q + 16'd1) : n_q;
        op_d[1].abs_d = abs_d;
        op_d[1].dn    = abs_d << lz;
        op_d[1].lz    = lz;
        op_d[1].neg   = n_q[15] ^ d_q[15];
        op_d[1].div0  = (d_q == 16'h0000);
        op_d[1].ovf   = (n_q == 16'h8000) && (d_q == 16'hFFFF);
        op_d[1].nzero = (n_q == 16'h0000);
        for (int s = 2; s < LATENCY; s++) op_d[s] = op_q[s-1];

        x_d[0] = C48_17 - 18'((34'(C32_17) * 34'(op_q[1].dn)) >> FRAC);
        for (int i = 1; i <= NR_ITERS; i++) x_d[i] = x_nxt[i-1];

        // X ~ 2^16/d, so |N|*X carries 32-lz extra fraction bits
        sh    = 6'd32 - {1'b0, op_q[LATENCY-1].lz};
        q_raw = 17'((34'(op_q[LATENCY-1].abs_n) * 34'(x_q[NR_ITERS])) >> sh);
        rem   = {2'b00, op_q[LATENCY-1].abs_n}
              - 18'(q_raw) * {2'b00, op_q[LATENCY-1].abs_d};
        if (rem[17])
            q_fix = q_raw - 17'd1;
        else if (rem >= {2'b00, op_q[LATENCY-1].abs_d})
            q_fix = q_raw + 17'd1;
        else
            q_fix = q_raw;
        mag = 16'(q_fix);

        q_d = q_q;
        if (vld_pipe_q[LATENCY-1]) begin
            if (op_q[LATENCY-1].div0)       q_d = 16'hFFFF;
            else if (op_q[LATENCY-1].ovf)   q_d = 16'h8000;
            else if (op_q[LATENCY-1].nzero) q_d = 16'h0000;
            else if (op_q[LATENCY-1].neg)   q_d = ~mag + 16'd1;
            else                            q_d = mag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            q_q        <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            q_q        <= q_d;
        end
    end

    // Datapath registers are qualified by vld_pipe_q and need no reset
    always_ff @(posedge clk) begin
        n_q  <= n_d;
        d_q  <= d_d;
        op_q <= op_d;
        x_q  <= x_d;
    end

    assign bus.out_valid = vld_pipe_q[LATENCY];
    assign bus.Q         = q_q;
endmodule

// File: tb/tb_newton_raphson_divide_16.sv
// Directed and streamed checks of the 16-bit Newton-Raphson divider.
module tb_newton_raphson_divide_16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    newton_raphson_divide_16_if bus ();
    newton_raphson_divide_16 dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] exp;
        int          t;
        logic [15:0] n;
        logic [15:0] d;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] ref_div(input logic [15:0] n, input logic [15:0] d);
        int ni, di;
        if (d == 16'h0000) return 16'hFFFF;
        ni = int'($signed(n));
        di = int'($signed(d));
        return 16'(ni / di);
    endfunction

    // Every out_valid must match the oldest outstanding operation, 6 edges on
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_valid", 16'(bus.out_valid), 16'h0000);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk($sformatf("q %h/%h", e.n, e.d), bus.Q, e.exp);
                chk("latency", 16'(cyc - e.t), 16'd6);
            end
        end
    end

    // Called at a negedge; operand is sampled on the following posedge
    task automatic send(input logic [15:0] n, input logic [15:0] d, input logic [15:0] exp);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.N = n;
        bus.D = d;
        e = '{exp: exp, t: cyc + 1, n: n, d: d};
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.in_valid = 1'b0;
        while (expq.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 16'(expq.size()), 16'd0);
        expq.delete();
        @(negedge clk);
    endtask

    task automatic one(input logic [15:0] n, input logic [15:0] d, input logic [15:0] exp);
        send(n, d, exp);
        drain();
    endtask

    initial begin
        // in_valid during reset must be ignored
        bus.in_valid = 1'b1;
        bus.N = 16'd8;
        bus.D = 16'd2;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_q", bus.Q, 16'h0000);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);

        one(16'd8,      16'd2,      16'h0004);
        one(16'd20,     16'd5,      16'h0004);
        one(16'd239,    16'd17,     16'h000E);
        one(16'hFFF8,   16'd2,      16'hFFFC);
        one(16'd7,      16'hFFFE,   16'hFFFD);
        one(16'hFFF9,   16'hFFFE,   16'h0003);
        one(16'h8000,   16'hFFFF,   16'h8000);
        one(16'd5,      16'h0000,   16'hFFFF);
        one(16'd0,      16'd9,      16'h0000);
        one(16'h7FFF,   16'd1,      16'h7FFF);
        one(16'd1,      16'h7FFF,   16'h0000);
        one(16'h8000,   16'd1,      16'h8000);
        one(16'd100,    16'hFFF9,   16'hFFF2);
        one(16'd1000,   16'd1000,   16'h0001);
        one(16'd999,    16'd1000,   16'h0000);
        one(16'h8000,   16'h8000,   16'h0001);
        one(16'h7FFF,   16'h8000,   16'h0000);
        one(16'h7FFF,   16'd3,      16'h2AAA);

        // Q holds its value while out_valid is low
        chk("q_hold", bus.Q, 16'h2AAA);
        chk("idle_valid", 16'(bus.out_valid), 16'd0);

        // 20 back-to-back operands
        for (int i = 0; i < 20; i++) begin
            logic [15:0] n, d;
            n = 16'($urandom);
            d = 16'($urandom);
            send(n, d, ref_div(n, d));
        end
        drain();

        // Reset with three operations in flight plus one concurrent with rst
        one(16'd100, 16'd7, 16'd14);
        send(16'd50, 16'd5, 16'd10);
        send(16'd60, 16'd5, 16'd12);
        send(16'd70, 16'd5, 16'd14);
        bus.in_valid = 1'b1;
        bus.N = 16'd90;
        bus.D = 16'd3;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 16'(bus.out_valid), 16'd0);
        chk("midrst_q", bus.Q, 16'h0000);
        expq.delete();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        one(16'd77, 16'd11, 16'd7);

        // Exact multiples and their neighbours around the correction boundary
        for (int i = 0; i < 1500; i++) begin
            int dv, kv, nv, lim;
            if (i % 3 == 0) dv = int'($signed(16'($urandom)));
            else            dv = int'($urandom_range(0, 400)) - 200;
            if (dv == 0) dv = 1;
            lim = 32768 / (dv < 0 ? -dv : dv);
            kv = int'($urandom_range(0, 2 * lim)) - lim;
            nv = kv * dv + int'($urandom_range(0, 2)) - 1;
            if (nv >= -32768 && nv <= 32767)
                send(16'(nv), 16'(dv), ref_div(16'(nv), 16'(dv)));
        end
        drain();

        // Random sweep
        for (int i = 0; i < 30000; i++) begin
            logic [15:0] n, d;
            n = 16'($urandom);
            d = (i % 4 == 0) ? 16'($urandom_range(0, 64)) : 16'($urandom);
            send(n, d, ref_div(n, d));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
